// File: rtl/shift_iter_if.sv
// rtl/shift_iter_if.sv - request/result handshake bundle for the iterative shifter
interface shift_iter_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH)
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [CNT_W-1:0] in_cnt;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, in_cnt, in_mode, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_cnt, in_mode, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/shift_iter.sv
// rtl/shift_iter.sv - one barrel-shifter stage per clock, ROL/SLL/ROR/SRL
module shift_iter #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  shift_iter_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [1:0] MODE_ROL = 2'b00;
  localparam logic [1:0] MODE_SLL = 2'b01;
  localparam logic [1:0] MODE_ROR = 2'b10;
  localparam logic [1:0] MODE_SRL = 2'b11;

  localparam logic [CNT_W-1:0] LAST_STAGE = CNT_W'(CNT_W - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_work;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_mode;
  logic [CNT_W-1:0] r_stage;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;

  logic [CNT_W:0]     w_amt;
  logic [CNT_W-1:0]   w_cnt_sh;
  logic               w_bit;
  logic [2*WIDTH-1:0] w_rol_full;
  logic [2*WIDTH-1:0] w_ror_full;
  logic [WIDTH-1:0]   w_moved;
  logic [WIDTH-1:0]   w_next;

  // Rotates come from shifting a doubled copy so the wrapped bits fall into the kept half.
  always_comb begin
    w_amt      = (CNT_W + 1)'(1) << r_stage;
    w_cnt_sh   = r_cnt >> r_stage;
    w_bit      = w_cnt_sh[0];
    w_rol_full = {r_work, r_work} << w_amt;
    w_ror_full = {r_work, r_work} >> w_amt;
    w_moved    = r_work;
    case (r_mode)
      MODE_ROL: w_moved = w_rol_full[2*WIDTH-1:WIDTH];
      MODE_SLL: w_moved = r_work << w_amt;
      MODE_ROR: w_moved = w_ror_full[WIDTH-1:0];
      MODE_SRL: w_moved = r_work >> w_amt;
      default:  w_moved = r_work;
    endcase
    w_next = w_bit ? w_moved : r_work;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_work      <= '0;
      r_cnt       <= '0;
      r_mode      <= '0;
      r_stage     <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            r_work     <= bus.in_data;
            r_cnt      <= bus.in_cnt;
            r_mode     <= bus.in_mode;
            r_stage    <= '0;
            r_in_ready <= 1'b0;
            r_state    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_work <= w_next;
          if (r_stage == LAST_STAGE) begin
            r_stage     <= '0;
            r_out_data  <= w_next;
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end else begin
            r_stage <= r_stage + 1'b1;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;

endmodule

// File: tb/tb_shift_iter.sv
// tb/tb_shift_iter.sv - directed and model-checked bench for shift_iter at 16 and 8 bits
module tb_shift_iter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_total = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  shift_iter_if #(.WIDTH(16), .CNT_W(4)) b16 ();
  shift_iter_if #(.WIDTH(8),  .CNT_W(3)) b8 ();

  shift_iter #(.WIDTH(16), .CNT_W(4)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(b16));
  shift_iter #(.WIDTH(8),  .CNT_W(3)) u_dut8  (.clk(clk), .rst_n(rst_n), .bus(b8));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Bit-at-a-time reference: c single-bit moves within a w-bit word.
  function automatic logic [15:0] model(input logic [15:0] d, input int c,
                                        input logic [1:0] m, input int w);
    logic [15:0] x;
    logic [15:0] msk;
    msk = (w == 16) ? 16'hFFFF : 16'h00FF;
    x = d & msk;
    for (int i = 0; i < c; i++) begin
      case (m)
        2'b00:   x = ((x << 1) | (x >> (w - 1))) & msk;
        2'b01:   x = (x << 1) & msk;
        2'b10:   x = (x >> 1) | ((x & 16'h1) << (w - 1));
        default: x = x >> 1;
      endcase
    end
    return x;
  endfunction

  task automatic op16(input logic [15:0] d, input logic [3:0] c, input logic [1:0] m,
                      output logic [15:0] res, output int lat);
    b16.in_data = d; b16.in_cnt = c; b16.in_mode = m; b16.in_valid = 1'b1;
    @(posedge clk); #1;
    b16.in_valid = 1'b0;
    lat = 0;
    while (!b16.out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    res = b16.out_data;
    if (b16.out_ready) begin @(posedge clk); #1; end
  endtask

  task automatic op8(input logic [7:0] d, input logic [2:0] c, input logic [1:0] m,
                     output logic [7:0] res, output int lat);
    b8.in_data = d; b8.in_cnt = c; b8.in_mode = m; b8.in_valid = 1'b1;
    @(posedge clk); #1;
    b8.in_valid = 1'b0;
    lat = 0;
    while (!b8.out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    res = b8.out_data;
    if (b8.out_ready) begin @(posedge clk); #1; end
  endtask

  typedef struct { logic [15:0] d; logic [3:0] c; logic [1:0] m; logic [15:0] e; } vec_t;
  vec_t vecs[$];

  initial begin
    logic [15:0] r16;
    logic [7:0]  r8;
    int          lat;

    b16.in_valid = 1'b0; b16.in_data = '0; b16.in_cnt = '0; b16.in_mode = '0; b16.out_ready = 1'b0;
    b8.in_valid  = 1'b0; b8.in_data  = '0; b8.in_cnt  = '0; b8.in_mode  = '0; b8.out_ready  = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", b16.in_ready, 1);
    chk("rst_out_valid", b16.out_valid, 0);
    chk("rst_out_data", b16.out_data, 0);
    chk("rst8_in_ready", b8.in_ready, 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    b16.out_ready = 1'b1;
    op16(16'h00FF, 4'd8, 2'b01, r16, lat);
    chk("sll_data", r16, 16'hFF00);
    chk("sll_lat", lat, 4);
    chk("sll_valid_1cyc", b16.out_valid, 0);
    chk("sll_ready_back", b16.in_ready, 1);

    vecs.push_back('{16'h1234, 4'd4,  2'b00, 16'h2341});
    vecs.push_back('{16'h1234, 4'd4,  2'b10, 16'h4123});
    vecs.push_back('{16'h8001, 4'd15, 2'b00, 16'hC000});
    vecs.push_back('{16'h8000, 4'd15, 2'b11, 16'h0001});
    vecs.push_back('{16'hBEEF, 4'd0,  2'b00, 16'hBEEF});
    vecs.push_back('{16'hBEEF, 4'd0,  2'b01, 16'hBEEF});
    vecs.push_back('{16'hBEEF, 4'd0,  2'b10, 16'hBEEF});
    vecs.push_back('{16'hBEEF, 4'd0,  2'b11, 16'hBEEF});
    vecs.push_back('{16'h8001, 4'd15, 2'b01, 16'h8000});
    vecs.push_back('{16'hF0F0, 4'd4,  2'b11, 16'h0F0F});
    vecs.push_back('{16'h0001, 4'd1,  2'b10, 16'h8000});
    vecs.push_back('{16'h1234, 4'd15, 2'b01, 16'h0000});
    vecs.push_back('{16'hA5C3, 4'd8,  2'b00, 16'hC3A5});
    foreach (vecs[i]) begin
      chk($sformatf("v%0d_rdy", i), b16.in_ready, 1);
      op16(vecs[i].d, vecs[i].c, vecs[i].m, r16, lat);
      chk($sformatf("v%0d_data", i), r16, vecs[i].e);
      chk($sformatf("v%0d_lat", i), lat, 4);
    end

    // Backpressure, with new request inputs wiggled while the op is in flight.
    b16.out_ready = 1'b0;
    b16.in_data = 16'h00F0; b16.in_cnt = 4'd4; b16.in_mode = 2'b01; b16.in_valid = 1'b1;
    @(posedge clk); #1;
    b16.in_data = 16'hFFFF; b16.in_cnt = 4'd1; b16.in_mode = 2'b11;
    chk("bp_rdy_shift", b16.in_ready, 0);
    lat = 0;
    while (!b16.out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    chk("bp_lat", lat, 4);
    chk("bp_data", b16.out_data, 16'h0F00);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_hold_valid%0d", k), b16.out_valid, 1);
      chk($sformatf("bp_hold_data%0d", k), b16.out_data, 16'h0F00);
      chk($sformatf("bp_hold_rdy%0d", k), b16.in_ready, 0);
    end
    b16.in_valid = 1'b0;
    b16.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", b16.out_valid, 0);
    chk("bp_release_rdy", b16.in_ready, 1);

    // Reset landing on the edge that would apply stage 2.
    b16.in_data = 16'h00FF; b16.in_cnt = 4'd15; b16.in_mode = 2'b00; b16.in_valid = 1'b1;
    @(posedge clk); #1;
    b16.in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("mid_rst_rdy", b16.in_ready, 1);
    chk("mid_rst_valid", b16.out_valid, 0);
    chk("mid_rst_data", b16.out_data, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("mid_rst_no_result", b16.out_valid, 0);
    op16(16'h0001, 4'd1, 2'b01, r16, lat);
    chk("post_rst_data", r16, 16'h0002);
    chk("post_rst_lat", lat, 4);

    for (int i = 0; i < 24; i++) begin
      logic [15:0] d;
      logic [3:0]  c;
      logic [1:0]  m;
      d = 16'($urandom_range(0, 65535));
      c = 4'($urandom_range(0, 15));
      m = 2'($urandom_range(0, 3));
      op16(d, c, m, r16, lat);
      chk($sformatf("rnd16_%0d_d%0h_c%0d_m%0d", i, d, c, m), r16, model(d, int'(c), m, 16));
    end

    op8(8'h81, 3'd1, 2'b10, r8, lat);
    chk("w8_ror_data", r8, 8'hC0);
    chk("w8_ror_lat", lat, 3);
    for (int i = 0; i < 40; i++) begin
      logic [7:0] d;
      logic [2:0] c;
      logic [1:0] m;
      d = 8'($urandom_range(0, 255));
      c = 3'($urandom_range(0, 7));
      m = 2'($urandom_range(0, 3));
      op8(d, c, m, r8, lat);
      chk($sformatf("rnd8_%0d_d%0h_c%0d_m%0d", i, d, c, m), {8'h0, r8}, model({8'h0, d}, int'(c), m, 8));
      chk($sformatf("rnd8_%0d_lat", i), lat, 3);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/shift_iter.md
# shift_iter

Multi-cycle, parametrised shift/rotate unit for the execute stage. It performs one logarithmic barrel-shifter stage per clock: stage k shifts by 2^k when count bit k is set. It replaces the fixed 16-bit shifter stages with a single WIDTH-generic block that supports four modes. The execute-stage control talks to it through a valid/ready handshake on both sides.

## Interface

**Parameters**
- WIDTH, default 16: data width. Must be a power of two, ≥ 2.
- CNT_W, default $clog2(WIDTH): shift-count width, which is also the number of stages.

**Ports**
- clk, input, 1: sole clock. All state updates on the rising edge.
- rst_n, input, 1: reset. Synchronous and active-low.
- in_valid, input, 1: operation request.
- in_ready, output, 1: high only in IDLE.
- in_data, input, WIDTH: operand.
- in_cnt, input, CNT_W: shift amount, 0..WIDTH-1.
- in_mode, input, 2: operation select.
  - 00: ROL
  - 01: SLL
  - 10: ROR
  - 11: SRL
- out_valid, output, 1: result available.
- out_ready, input, 1: consumer accepts the result.
- out_data, output, WIDTH: result, registered.

## Operation

**State machine: IDLE, SHIFT, DONE.**
- **IDLE**
  - in_ready=1.
  - On in_valid&&in_ready: latch in_data into the working register, latch in_cnt and in_mode, clear the stage index to 0, go to SHIFT.
- **SHIFT**
  - Each cycle, apply stage k = stage index.
  - If cnt[k]=1, move the working register by 2^k in the latched mode:
    - SLL: zero-fill at the LSBs.
    - SRL: zero-fill at the MSBs.
    - ROL/ROR: circular.
  - If cnt[k]=0, the register holds.
  - Increment the stage index.
  - After stage CNT_W-1 is applied, go to DONE.
- **DONE**
  - out_valid=1; out_data = working register.
  - On out_ready=1, go to IDLE.
  - out_data keeps its last value in IDLE. Consumers use it only when out_valid=1.

**Behaviour rules**
- Latency is fixed and independent of the count. A count of 0 still walks all CNT_W stages and returns in_data unchanged.
- in_data, in_cnt and in_mode are ignored outside IDLE. The latched copies are used for the whole operation.
- Only one operation is in flight. in_ready=0 in SHIFT and DONE, so a new request waits in IDLE.
- Shifts are modulo WIDTH by construction. No count of WIDTH or more can be expressed.
- Reset (rst_n=0 at a clock edge), from any state including mid-SHIFT or DONE:
  - State goes to IDLE; the in-flight operation is discarded and no result is produced.
  - out_valid=0, out_data=0, working register=0, stage index=0.
- Reset values: in_ready=1 (IDLE), out_valid=0, out_data=0.

## Timing

- Request accepted at edge E0 → state SHIFT.
- Stage k is applied at edge E(k+1). At edge E(CNT_W), state goes to DONE.
- out_valid is high from the cycle after E(CNT_W). That is 4 cycles after acceptance for WIDTH=16.
- out_valid and out_data are stable until out_valid&&out_ready is sampled at an edge. After that edge: out_valid=0, in_ready=1.
- If out_ready is already high when DONE is entered, DONE lasts exactly one cycle.
- Earliest next acceptance: the edge after returning to IDLE. Minimum request-to-request spacing is CNT_W+2 cycles with out_ready held high.
- No combinational path from any input to any output. in_ready and out_valid are decoded from the state register only.

## Test plan

Default parameters (WIDTH=16, CNT_W=4) unless noted.

1. **SLL:** in_data=0x00FF, in_cnt=8, in_mode=01, out_ready=1.
   - out_data=0xFF00.
   - out_valid rises exactly 4 cycles after acceptance and stays high for 1 cycle.
2. **Rotates:**
   - in_data=0x1234, cnt=4, ROL → 0x2341.
   - Same operand, ROR → 0x4123.
   - in_data=0x8001, cnt=15, ROL → 0xC000.
3. **SRL and count 0:**
   - in_data=0x8000, cnt=15, SRL → 0x0001.
   - in_data=0xBEEF, cnt=0, any mode → 0xBEEF, with the same 4-cycle latency.
4. **Backpressure:**
   - Hold out_ready=0 for 5 cycles after out_valid rises. out_valid and out_data stay constant and in_ready stays 0.
   - Change in_data and in_valid during SHIFT. The result is unaffected.
5. **Reset mid-operation:** assert rst_n=0 for one edge at stage 2.
   - Next cycle: in_ready=1, out_valid=0, out_data=0.
   - A fresh SLL of 0x0001 by 1 then returns 0x0002.
6. **Parameter sweep:** WIDTH=8, CNT_W=3.
   - 0x81, cnt=1, ROR → 0xC0; latency 3 cycles.
   - Random regression of all modes and counts against a software model.
